// File: rtl/axil_slave_delay_mem_pkg.sv
// Shared types for the AXI-Lite delayed-response memory slave: response codes,
// channel FSM states and the LFSR feedback mask.
package pkg_axil_slave;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_A,
    W_WAIT_D,
    W_DELAY,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_RESP
  } r_state_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axil_slave_delay_mem_lfsr.sv
// 16-bit Galois LFSR used to draw pseudo-random response delays.
module axil_lfsr16
  import pkg_axil_slave::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axil_slave_delay_mem.sv
// AXI-Lite slave memory that answers each write/read after a bounded delay.
// Define AXIL_SLAVE_RAND_DELAY_EN to draw delays from an LFSR; otherwise every delay is DELAY_MIN.
module axil_slave_delay_mem
  import pkg_axil_slave::*;
#(
  parameter int                          AXI_DATA_WIDTH  = 32,
  parameter int                          AXI_ADDR_WIDTH  = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]   AXI_ADDR_OFFSET = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]   AXI_ADDR_RANGE  = 32'h00FF_FFFF,
  parameter int                          MEM_DEPTH       = 256,
  parameter int                          DELAY_MIN       = 2,
  parameter int                          DELAY_MAX       = 17,
  parameter logic [15:0]                 LFSR_SEED       = 16'hACE1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(DELAY_MAX + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);

  // An address hits memory only if it is inside the window and maps below MEM_DEPTH
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - AXI_ADDR_OFFSET;
    return (addr >= AXI_ADDR_OFFSET) && (off <= AXI_ADDR_RANGE) && ((off >> SHIFT) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - AXI_ADDR_OFFSET;
    return IDX_W'(off >> SHIFT);
  endfunction

  logic [CNT_W-1:0] w_delay;
  logic [CNT_W-1:0] r_delay;

`ifdef AXIL_SLAVE_RAND_DELAY_EN
  localparam int SPAN = DELAY_MAX - DELAY_MIN + 1;
  localparam int K    = (SPAN > 1) ? $clog2(SPAN) : 1;

  logic [15:0] lfsr_state;
  logic        lfsr_unused;

  axil_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (aclk),
    .rst   (areset),
    .en    (1'b1),
    .state (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state;

  // K bits cover less than twice the span, so one fold brings r into range
  function automatic logic [CNT_W-1:0] fold_delay(input logic [K-1:0] r);
    int v;
    v = int'(r);
    if (v > SPAN - 1) begin
      v = v - SPAN;
    end
    return CNT_W'(DELAY_MIN + v);
  endfunction

  assign w_delay = fold_delay(lfsr_state[K-1:0]);
  assign r_delay = fold_delay(lfsr_state[15 -: K]);
`else
  localparam int cfg_unused = DELAY_MAX + int'(LFSR_SEED);

  assign w_delay = CNT_W'(DELAY_MIN);
  assign r_delay = CNT_W'(DELAY_MIN);
`endif

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_t                  w_state_q, w_state_d;
  logic [CNT_W-1:0]          w_cnt_q, w_cnt_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  resp_t                     bresp_q, bresp_d;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]         w_strb_q, w_strb_d;

  r_state_t                  r_state_q, r_state_d;
  logic [CNT_W-1:0]          r_cnt_q, r_cnt_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  resp_t                     rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                      aw_hs, w_hs, ar_hs, commit;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_widx;
  logic [AXI_DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]         mem_wstrb;

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;
  assign ar_hs = s_axil_arvalid && arready_q;

  // Whichever beat arrives last is taken straight from the bus; the earlier one is held
  assign wr_addr = aw_hs ? s_axil_awaddr : w_addr_q;
  assign wr_data = w_hs ? s_axil_wdata : w_data_q;
  assign wr_strb = w_hs ? s_axil_wstrb : w_strb_q;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    commit    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = addr_idx(wr_addr);
    mem_wdata = wr_data;
    mem_wstrb = wr_strb;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = !aw_hs;
        wready_d  = !w_hs;
        if (aw_hs) begin
          w_addr_d = s_axil_awaddr;
        end
        if (w_hs) begin
          w_data_d = s_axil_wdata;
          w_strb_d = s_axil_wstrb;
        end
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          w_state_d = W_WAIT_D;
        end else if (w_hs) begin
          w_state_d = W_WAIT_A;
        end
      end
      W_WAIT_A: begin
        if (aw_hs) begin
          awready_d = 1'b0;
          commit    = 1'b1;
        end
      end
      W_WAIT_D: begin
        if (w_hs) begin
          wready_d = 1'b0;
          commit   = 1'b1;
        end
      end
      W_DELAY: begin
        if (w_cnt_q == CNT_W'(1)) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      mem_we    = addr_ok(wr_addr);
      bresp_d   = addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      w_cnt_d   = w_delay;
      w_state_d = W_DELAY;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          if (addr_ok(s_axil_araddr)) begin
            rdata_d = mem_q[addr_idx(s_axil_araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_cnt_d   = r_delay;
          r_state_d = R_DELAY;
        end
      end
      R_DELAY: begin
        if (r_cnt_q == CNT_W'(1)) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge aclk) begin
    w_addr_q <= w_addr_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

  // Reads sample mem_q before this edge's write lands, so a colliding read sees old data
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_wstrb[b]) begin
          mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

endmodule
